mem_stage_hs: RTL and testbench

Parametrised successor to the single-cycle memory stage of the pipelined core. Adds a request/acknowledge data-memory port with wait states and a stall output. Adds byte/half/word loads and stores with sign/zero extension and lane byte-enables. Sits between EX and WB; also feeds the forwarding unit and returns branch resolution to IF.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_hs_if.sv | 28 ++
 rtl/mem_lane_align.sv | 70 +++++++
 rtl/mem_stage_hs.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the handshaked memory stage: access-size encodings, FSM states
// and the byte-lane width derivation used by the stage, its aligner and its bus.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int be_width(input int xlen);
    return xlen / 8;
  endfunction

  // Number of address bits that select a byte lane inside one bus word.
  function automatic int lane_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_hs_if
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
);
  localparam int BE_W = be_width(XLEN);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [BE_W-1:0] dmem_be;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane aligner: store data replication and byte enables,
// plus load lane extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BE_W = be_width(XLEN),
  localparam int LW   = lane_width(XLEN)
) (
  input  logic [1:0]      size_i,
  input  logic [LW-1:0]   lane_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]    rbytes [BE_W];
  logic [LW-1:0] lane_eff;
  logic [LW-1:0] lane_hi;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_rbytes
      assign rbytes[gi] = rdata_i[8*gi +: 8];
    end
  endgenerate

  // Misaligned offsets are truncated to the natural alignment of the access.
  always_comb begin
    lane_eff = '0;
    case (size_i)
      SIZE_BYTE: lane_eff = lane_i;
      SIZE_HALF: lane_eff = {lane_i[LW-1:1], 1'b0};
      default:   lane_eff = '0;
    endcase
  end

  assign lane_hi = {lane_eff[LW-1:1], 1'b1};
  assign ld_byte = rbytes[lane_eff];
  assign ld_half = {rbytes[lane_hi], rbytes[lane_eff]};

  always_comb begin
    be_o        = '1;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o        = BE_W'(1) << lane_eff;
        wdata_o     = {BE_W{store_data_i[7:0]}};
        load_data_o = {{(XLEN-8){ld_byte[7] & ~uns_i}}, ld_byte};
      end
      SIZE_HALF: begin
        be_o        = BE_W'(3) << lane_eff;
        wdata_o     = {(BE_W/2){store_data_i[15:0]}};
        load_data_o = {{(XLEN-16){ld_half[15] & ~uns_i}}, ld_half};
      end
      default: begin
        be_o        = '1;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipelined memory stage with a wait-state data-memory handshake and stall output.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int RA_W = 5,
  localparam int BE_W = be_width(XLEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             is_branch,
  input  logic [XLEN-1:0]  pc_branch,
  input  logic             alu_zero,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic             mem_to_reg,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  data_t,
  input  logic [RA_W-1:0]  reg_addr,
  input  logic             reg_write,
  mem_stage_hs_if.master   dmem,
  output logic             stall,
  output logic [RA_W-1:0]  reg_probe,
  output logic [XLEN-1:0]  data_probe,
  output logic             write_probe,
  output logic [XLEN-1:0]  reg_data,
  output logic [RA_W-1:0]  reg_addr_out,
  output logic             reg_write_out,
  output logic             is_branch_out,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  output logic             misaligned,
`endif
  output logic [XLEN-1:0]  pc_branch_out
);

  localparam int LW = lane_width(XLEN);

  typedef struct packed {
    logic            is_branch;
    logic            alu_zero;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            mem_to_reg;
    logic            reg_write;
    logic [RA_W-1:0] reg_addr;
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data;
  } instr_t;

  state_e          state_q, state_d;
  instr_t          buf_q, buf_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] reg_data_q, reg_data_d;
  logic [RA_W-1:0] reg_addr_q, reg_addr_d;
  logic            reg_write_q, reg_write_d;
  logic            is_branch_q, is_branch_d;
  logic [XLEN-1:0] pc_branch_q, pc_branch_d;

  instr_t          in_instr;
  instr_t          cur;
  logic            mem_op;
  logic            is_load;
  logic            trap_cur;
  logic            req_raw;
  logic            req;
  logic            ack;
  logic            load_result;
  logic            load_bubble;
  logic [XLEN-1:0] rdata_src;
  logic [XLEN-1:0] res_data;
  logic [BE_W-1:0] align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_ldata;

  assign in_instr = '{
    is_branch:    is_branch,
    alu_zero:     alu_zero,
    mem_read:     mem_read,
    mem_write:    mem_write,
    mem_size:     mem_size,
    mem_unsigned: mem_unsigned,
    mem_to_reg:   mem_to_reg,
    reg_write:    reg_write,
    reg_addr:     reg_addr,
    pc_branch:    pc_branch,
    alu_out:      alu_out,
    store_data:   data_t
  };

  // Once a request is outstanding the buffered copy is the instruction in the stage.
  assign cur     = (state_q == S_IDLE) ? in_instr : buf_q;
  assign mem_op  = cur.mem_read | cur.mem_write;
  assign is_load = cur.mem_read & ~cur.mem_write;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap_cur = mem_op &
                    (((cur.mem_size == SIZE_HALF) & cur.alu_out[0]) |
                     (cur.mem_size[1] & (|cur.alu_out[LW-1:0])));
`else
  assign trap_cur = 1'b0;
`endif

  always_comb begin
    req_raw = 1'b0;
    case (state_q)
      S_IDLE:  req_raw = we & mem_op & ~trap_cur;
      S_WAIT:  req_raw = 1'b1;
      default: req_raw = 1'b0;
    endcase
  end

  // Reset drops an outstanding request in the same cycle it is asserted.
  assign req   = req_raw & ~reset;
  assign ack   = req & dmem.dmem_ack;
  assign stall = (req & ~dmem.dmem_ack) | (state_q == S_DONE);

  assign rdata_src = (state_q == S_DONE) ? rdata_q : dmem.dmem_rdata;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size_i       (cur.mem_size),
    .lane_i       (cur.alu_out[LW-1:0]),
    .uns_i        (cur.mem_unsigned),
    .store_data_i (cur.store_data),
    .rdata_i      (rdata_src),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .load_data_o  (align_ldata)
  );

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = cur.mem_write;
  assign dmem.dmem_addr  = {cur.alu_out[XLEN-1:LW], {LW{1'b0}}};
  assign dmem.dmem_wdata = align_wdata;
  assign dmem.dmem_be    = align_be;

  assign res_data = (is_load & cur.mem_to_reg) ? align_ldata : cur.alu_out;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rdata_d     = rdata_q;
    load_result = 1'b0;
    load_bubble = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (we) begin
          if (mem_op & ~trap_cur & ~ack) begin
            buf_d       = in_instr;
            state_d     = S_WAIT;
            load_bubble = 1'b1;
          end else begin
            load_result = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ack) begin
          if (we) begin
            load_result = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rdata_d = dmem.dmem_rdata;
            state_d = S_DONE;
          end
        end else if (we) begin
          load_bubble = 1'b1;
        end
      end
      S_DONE: begin
        if (we) begin
          load_result = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_data_d  = reg_data_q;
    reg_addr_d  = reg_addr_q;
    reg_write_d = reg_write_q;
    is_branch_d = is_branch_q;
    pc_branch_d = pc_branch_q;
    if (load_result) begin
      reg_data_d  = res_data;
      reg_addr_d  = cur.reg_addr;
      reg_write_d = cur.reg_write & ~trap_cur;
      is_branch_d = cur.is_branch & cur.alu_zero;
      pc_branch_d = cur.pc_branch;
    end
    if (load_bubble) begin
      reg_write_d = 1'b0;
      is_branch_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      rdata_q     <= '0;
      reg_data_q  <= '0;
      reg_addr_q  <= '0;
      reg_write_q <= 1'b0;
      is_branch_q <= 1'b0;
      pc_branch_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rdata_q     <= rdata_d;
      reg_data_q  <= reg_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_write_q <= reg_write_d;
      is_branch_q <= is_branch_d;
      pc_branch_q <= pc_branch_d;
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = misaligned_q;
    if (load_result) misaligned_d = trap_cur;
    if (load_bubble) misaligned_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= misaligned_d;
  end

  assign misaligned = misaligned_q;
`endif

  assign reg_probe     = cur.reg_addr;
  assign data_probe    = cur.alu_out;
  assign write_probe   = cur.reg_write & ~cur.mem_to_reg;
  assign reg_data      = reg_data_q;
  assign reg_addr_out  = reg_addr_q;
  assign reg_write_out = reg_write_q;
  assign is_branch_out = is_branch_q;
  assign pc_branch_out = pc_branch_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: expected writebacks are queued when an
// instruction is driven and retired when the stage advances with a register write.
module tb_mem_stage_hs;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, we, is_branch, alu_zero, mem_read, mem_write;
  logic [1:0]      mem_size;
  logic            mem_unsigned, mem_to_reg, reg_write;
  logic [XLEN-1:0] pc_branch, alu_out, data_t;
  logic [RA_W-1:0] reg_addr;
  logic            stall, write_probe, reg_write_out, is_branch_out;
  logic [RA_W-1:0] reg_probe, reg_addr_out;
  logic [XLEN-1:0] data_probe, reg_data, pc_branch_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic            misaligned;
`endif

  mem_stage_hs_if #(.XLEN(XLEN)) dmem_bus ();

  mem_stage_hs #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .is_branch     (is_branch),
    .pc_branch     (pc_branch),
    .alu_zero      (alu_zero),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .mem_to_reg    (mem_to_reg),
    .alu_out       (alu_out),
    .data_t        (data_t),
    .reg_addr      (reg_addr),
    .reg_write     (reg_write),
    .dmem          (dmem_bus),
    .stall         (stall),
    .reg_probe     (reg_probe),
    .data_probe    (data_probe),
    .write_probe   (write_probe),
    .reg_data      (reg_data),
    .reg_addr_out  (reg_addr_out),
    .reg_write_out (reg_write_out),
    .is_branch_out (is_branch_out),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misaligned    (misaligned),
`endif
    .pc_branch_out (pc_branch_out)
  );

  typedef struct {
    logic [XLEN-1:0] data;
    logic [RA_W-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  task automatic clear_inputs();
    we = 0; is_branch = 0; alu_zero = 0; mem_read = 0; mem_write = 0;
    mem_size = 2'd2; mem_unsigned = 0; mem_to_reg = 0; reg_write = 0;
    pc_branch = '0; alu_out = '0; data_t = '0; reg_addr = '0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] d, input logic [RA_W-1:0] a);
    exp_t e;
    e.data = d;
    e.addr = a;
    sb_q.push_back(e);
  endtask

  // Advance one clock; a register write retired by an advancing edge pops the scoreboard.
  task automatic step();
    logic adv;
    exp_t e;
    adv = we & ~reset;
    @(posedge clk);
    #1;
    if (adv && reg_write_out) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got r%0d=%h, required no writeback", reg_addr_out, reg_data);
      end else begin
        e = sb_q.pop_front();
        if (reg_data !== e.data || reg_addr_out !== e.addr)
          $display("FAIL sb_writeback: got r%0d=%h, required r%0d=%h", reg_addr_out, reg_data, e.addr, e.data);
        else begin
          n_pass++;
          $display("wb r%0d = %h", reg_addr_out, reg_data);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    step(); step();
    n_checks++; if (reg_data !== '0) $display("FAIL rst_reg_data: got %h required 0", reg_data); else n_pass++;
    n_checks++; if (reg_write_out !== 1'b0) $display("FAIL rst_reg_write: got %b required 0", reg_write_out); else n_pass++;
    n_checks++; if (is_branch_out !== 1'b0 || pc_branch_out !== '0) $display("FAIL rst_branch: got %b/%h required 0/0", is_branch_out, pc_branch_out); else n_pass++;
    n_checks++; if (stall !== 1'b0 || dmem_bus.dmem_req !== 1'b0) $display("FAIL rst_req_stall: got %b/%b required 0/0", dmem_bus.dmem_req, stall); else n_pass++;
    reset = 0;
    $display("reset done");
  endtask

  task automatic test_alu();
    clear_inputs();
    we = 1; alu_out = 32'h1234_5678; reg_addr = 5'd5; reg_write = 1; dmem_bus.dmem_ack = 1;
    #1;
    n_checks++; if (write_probe !== 1'b1 || reg_probe !== 5'd5 || data_probe !== 32'h1234_5678)
      $display("FAIL alu_probe: got %b/%0d/%h required 1/5/12345678", write_probe, reg_probe, data_probe); else n_pass++;
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL alu_no_req: got %b required 0", dmem_bus.dmem_req); else n_pass++;
    push_exp(32'h1234_5678, 5'd5);
    step();
    we = 0; alu_out = 32'h0BAD_0BAD; reg_addr = 5'd6;
    step();
    n_checks++; if (reg_data !== 32'h1234_5678) $display("FAIL alu_hold: got %h required 12345678", reg_data); else n_pass++;
  endtask

  task automatic test_branch();
    clear_inputs();
    we = 1; is_branch = 1; alu_zero = 1; pc_branch = 32'h40;
    step();
    n_checks++; if (is_branch_out !== 1'b1 || pc_branch_out !== 32'h40)
      $display("FAIL br_taken: got %b/%h required 1/00000040", is_branch_out, pc_branch_out); else n_pass++;
    alu_zero = 0; pc_branch = 32'h80;
    step();
    n_checks++; if (is_branch_out !== 1'b0 || pc_branch_out !== 32'h80)
      $display("FAIL br_not_taken: got %b/%h required 0/00000080", is_branch_out, pc_branch_out); else n_pass++;
    $display("branch done");
  endtask

  task automatic test_store();
    logic [31:0] addrs [3] = '{32'h100, 32'h102, 32'h102};
    logic [1:0]  sizes [3] = '{2'd2, 2'd0, 2'd1};
    logic [31:0] datas [3] = '{32'hDEAD_BEEF, 32'h0000_00AB, 32'h1234_CDEF};
    logic [3:0]  bes   [3] = '{4'hF, 4'h4, 4'hC};
    logic [31:0] wds   [3] = '{32'hDEAD_BEEF, 32'hABAB_ABAB, 32'hCDEF_CDEF};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      we = 1; mem_write = 1; mem_read = (i == 1); mem_size = sizes[i];
      alu_out = addrs[i]; data_t = datas[i]; dmem_bus.dmem_ack = 1;
      #1;
      n_checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1 || stall !== 1'b0)
        $display("FAIL st_req%0d: req/we/stall got %b/%b/%b required 1/1/0", i, dmem_bus.dmem_req, dmem_bus.dmem_we, stall); else n_pass++;
      n_checks++; if (dmem_bus.dmem_be !== bes[i] || dmem_bus.dmem_wdata !== wds[i] || dmem_bus.dmem_addr !== {addrs[i][31:2], 2'b00})
        $display("FAIL st_lane%0d: be/wdata/addr got %h/%h/%h required %h/%h", i, dmem_bus.dmem_be, dmem_bus.dmem_wdata, dmem_bus.dmem_addr, bes[i], wds[i]); else n_pass++;
      step();
      n_checks++; if (reg_write_out !== 1'b0 || stall !== 1'b0)
        $display("FAIL st_wb%0d: reg_write_out/stall got %b/%b required 0/0", i, reg_write_out, stall); else n_pass++;
      $display("store %0d at %h", i, addrs[i]);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104, 32'h200};
    logic [1:0]  sizes [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        m2r   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rds   [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_1234, 32'h1234_F00F, 32'hA5A5_0001, 32'h7777_7777};
    logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00F, 32'hA5A5_0001, 32'h0000_0200};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      we = 1; mem_read = 1; mem_size = sizes[i]; mem_unsigned = unss[i]; mem_to_reg = m2r[i];
      alu_out = addrs[i]; reg_addr = 5'(i + 1); reg_write = 1;
      dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = rds[i];
      #1;
      n_checks++; if (dmem_bus.dmem_addr !== {addrs[i][31:2], 2'b00} || dmem_bus.dmem_we !== 1'b0 || write_probe !== ~m2r[i])
        $display("FAIL ld_req%0d: addr/we/wprobe got %h/%b/%b", i, dmem_bus.dmem_addr, dmem_bus.dmem_we, write_probe); else n_pass++;
      push_exp(exps[i], 5'(i + 1));
      step();
    end
  endtask

  task automatic test_wait_load();
    clear_inputs();
    we = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_addr = 5'd9; alu_out = 32'h104;
    push_exp(32'h1122_3344, 5'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (stall !== 1'b1 || dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 32'h104)
        $display("FAIL wait_stall%0d: stall/req/addr got %b/%b/%h required 1/1/00000104", k, stall, dmem_bus.dmem_req, dmem_bus.dmem_addr); else n_pass++;
      step();
      n_checks++; if (reg_write_out !== 1'b0) $display("FAIL wait_bubble%0d: got %b required 0", k, reg_write_out); else n_pass++;
      alu_out = 32'hFFF0; reg_addr = 5'd3;
    end
    n_checks++; if (reg_probe !== 5'd9) $display("FAIL wait_probe: got %0d required 9", reg_probe); else n_pass++;
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'h1122_3344;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL wait_ack_stall: got %b required 0", stall); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_ack_we0();
    clear_inputs();
    we = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_addr = 5'd12; alu_out = 32'h108;
    push_exp(32'hCAFE_F00D, 5'd12);
    step();
    we = 0; dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = 32'h0;
    #1;
    n_checks++; if (stall !== 1'b1 || dmem_bus.dmem_req !== 1'b0)
      $display("FAIL done_stall: stall/req got %b/%b required 1/0", stall, dmem_bus.dmem_req); else n_pass++;
    step();
    n_checks++; if (stall !== 1'b1 || reg_write_out !== 1'b0)
      $display("FAIL done_hold: stall/reg_write_out got %b/%b required 1/0", stall, reg_write_out); else n_pass++;
    we = 1;
    step();
    clear_inputs();
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL done_exit: stall got %b required 0", stall); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz;
    logic [1:0]  lane;
    logic [31:0] rd;
    logic [31:0] addr;
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      we = 1; reg_write = 1; reg_addr = 5'($urandom_range(1, 31));
      sz = 2'($urandom_range(0, 2));
      lane = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      addr = {$urandom, 2'b00} | {30'h0, lane};
      rd = $urandom;
      alu_out = addr;
      if (i % 2 == 1) begin
        mem_read = 1; mem_to_reg = 1; mem_size = sz; mem_unsigned = 1'($urandom_range(0, 1));
        dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = rd;
        push_exp(exp_load(rd, lane, sz, mem_unsigned), reg_addr);
      end else begin
        push_exp(addr, reg_addr);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_misalign();
    clear_inputs();
    we = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_addr = 5'd4; mem_size = 2'd1;
    alu_out = 32'h101; dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'h1234_8765;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    #1;
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL mis_no_req: got %b required 0", dmem_bus.dmem_req); else n_pass++;
    step();
    n_checks++; if (misaligned !== 1'b1 || reg_write_out !== 1'b0)
      $display("FAIL mis_trap: misaligned/reg_write_out got %b/%b required 1/0", misaligned, reg_write_out); else n_pass++;
    clear_inputs();
    we = 1; reg_write = 1; reg_addr = 5'd8; alu_out = 32'h55;
    push_exp(32'h55, 5'd8);
    step();
    n_checks++; if (misaligned !== 1'b0) $display("FAIL mis_clear: got %b required 0", misaligned); else n_pass++;
`else
    #1;
    n_checks++; if (dmem_bus.dmem_addr !== 32'h100 || dmem_bus.dmem_req !== 1'b1)
      $display("FAIL mis_trunc_req: addr/req got %h/%b required 00000100/1", dmem_bus.dmem_addr, dmem_bus.dmem_req); else n_pass++;
    push_exp(32'hFFFF_8765, 5'd4);
    step();
    clear_inputs();
    we = 1; mem_write = 1; mem_size = 2'd2; alu_out = 32'h102; data_t = 32'h0102_0304; dmem_bus.dmem_ack = 1;
    #1;
    n_checks++; if (dmem_bus.dmem_be !== 4'hF || dmem_bus.dmem_addr !== 32'h100)
      $display("FAIL mis_trunc_word: be/addr got %h/%h required f/00000100", dmem_bus.dmem_be, dmem_bus.dmem_addr); else n_pass++;
    step();
`endif
    clear_inputs();
  endtask

  task automatic test_reset_wait();
    clear_inputs();
    we = 1; mem_read = 1; alu_out = 32'h10C;
    step();
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL rw_pre_stall: got %b required 1", stall); else n_pass++;
    reset = 1;
    step();
    n_checks++; if (dmem_bus.dmem_req !== 1'b0 || stall !== 1'b0)
      $display("FAIL rw_req: req/stall got %b/%b required 0/0", dmem_bus.dmem_req, stall); else n_pass++;
    n_checks++; if (reg_data !== '0 || reg_addr_out !== '0 || pc_branch_out !== '0 || is_branch_out !== 1'b0)
      $display("FAIL rw_outputs: reg_data/addr/pc got %h/%0d/%h required 0", reg_data, reg_addr_out, pc_branch_out); else n_pass++;
    reset = 0; we = 0;
    #1;
    n_checks++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL rw_idle: req got %b required 0", dmem_bus.dmem_req); else n_pass++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_load_ext();
    test_wait_load();
    test_ack_we0();
    test_back_to_back();
    test_misalign();
    test_reset_wait();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: %0d writebacks outstanding, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
